// File: rtl/priority_scanner_pkg.sv
// prio_scan_pkg: scanner state type, index-width and popcount helpers.
package prio_scan_pkg;
    typedef enum logic {IDLE, SCAN} state_e;
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
    function automatic logic [8:0] popcount(input logic [255:0] v);
        popcount = '0;
        for (int i = 0; i < 256; i++) popcount += 9'(v[i]);
    endfunction
endpackage

// File: rtl/priority_scanner_if.sv
// priority_scanner_if: load and index handshakes of priority_scanner.
interface priority_scanner_if #(parameter int WIDTH = 32);
    import prio_scan_pkg::*;
    localparam int IDX_W = idx_width(WIDTH);
    logic             load_valid_i;
    logic             load_ready_o;
    logic [WIDTH-1:0] load_data_i;
    logic             idx_valid_o;
    logic             idx_ready_i;
    logic [IDX_W-1:0] idx_o;
    logic             last_o;
    modport master (
        output load_valid_i, load_data_i, idx_ready_i,
        input  load_ready_o, idx_valid_o, idx_o, last_o
    );
    modport slave (
        input  load_valid_i, load_data_i, idx_ready_i,
        output load_ready_o, idx_valid_o, idx_o, last_o
    );
endinterface

// File: rtl/priority_scanner_find_first.sv
// prio_find_first: index and isolated bit of the highest-priority set bit.
module prio_find_first
    import prio_scan_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 0
) (
    input  logic [WIDTH-1:0]            vec_i,
    output logic [idx_width(WIDTH)-1:0] idx_o,
    output logic [WIDTH-1:0]            one_hot_o
);
    localparam int IDX_W = idx_width(WIDTH);
    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++)
            if (vec_i[MSB_FIRST != 0 ? i : WIDTH-1-i]) idx_o = IDX_W'(MSB_FIRST != 0 ? i : WIDTH-1-i);
        one_hot_o = |vec_i ? WIDTH'(1) << idx_o : '0;
    end
endmodule

// File: rtl/priority_scanner.sv
// priority_scanner: emits the index of every set bit of a loaded vector, one per cycle.
// Define PRIO_SCAN_COUNT_EN to add count_o (set bits still pending).
module priority_scanner
    import prio_scan_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    priority_scanner_if.slave bus,
    output logic busy_o
`ifdef PRIO_SCAN_COUNT_EN
    ,
    output logic [idx_width(WIDTH):0] count_o
`endif
);
    localparam int IDX_W = idx_width(WIDTH);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d, one_hot;
    logic [IDX_W-1:0] ff_idx;
    logic             idx_take, load_take;

    prio_find_first #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_ff (
        .vec_i     (pend_q),
        .idx_o     (ff_idx),
        .one_hot_o (one_hot)
    );

    // A load is only accepted when idle or while the last index drains, so it overrides the clear.
    always_comb begin
        busy_o           = state_q == SCAN;
        bus.idx_valid_o  = busy_o;
        bus.idx_o        = busy_o ? ff_idx : '0;
        bus.last_o       = busy_o && (pend_q == one_hot);
        idx_take         = bus.idx_valid_o && bus.idx_ready_i;
        bus.load_ready_o = !rst_i && (!busy_o || (idx_take && bus.last_o));
        load_take        = bus.load_valid_i && bus.load_ready_o;
        pend_d           = load_take ? bus.load_data_i : idx_take ? pend_q & ~one_hot : pend_q;
        state_d          = |pend_d ? SCAN : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

`ifdef PRIO_SCAN_COUNT_EN
    localparam int CNT_W = IDX_W + 1;
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = load_take ? CNT_W'(popcount(256'(bus.load_data_i)))
                        : idx_take ? count_q - CNT_W'(1) : count_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else count_q <= count_d;
    end
    assign count_o = count_q;
`endif
endmodule

// File: tb/tb_priority_scanner.sv
// tb_priority_scanner: directed checks of priority_scanner across priority order and widths.
module tb_priority_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    priority_scanner_if #(.WIDTH(32))  a_if ();
    priority_scanner_if #(.WIDTH(32))  m_if ();
    priority_scanner_if #(.WIDTH(2))   n_if ();
    priority_scanner_if #(.WIDTH(256)) w_if ();
    logic a_busy, m_busy, n_busy, w_busy;
    logic [5:0] a_cnt, m_cnt;
    logic [1:0] n_cnt;
    logic [8:0] w_cnt;

`ifdef PRIO_SCAN_COUNT_EN
    priority_scanner #(.WIDTH(32), .MSB_FIRST(0)) u_a (.clk_i(clk), .rst_i(rst), .bus(a_if), .busy_o(a_busy), .count_o(a_cnt));
    priority_scanner #(.WIDTH(32), .MSB_FIRST(1)) u_m (.clk_i(clk), .rst_i(rst), .bus(m_if), .busy_o(m_busy), .count_o(m_cnt));
    priority_scanner #(.WIDTH(2), .MSB_FIRST(0)) u_n (.clk_i(clk), .rst_i(rst), .bus(n_if), .busy_o(n_busy), .count_o(n_cnt));
    priority_scanner #(.WIDTH(256), .MSB_FIRST(0)) u_w (.clk_i(clk), .rst_i(rst), .bus(w_if), .busy_o(w_busy), .count_o(w_cnt));
`else
    priority_scanner #(.WIDTH(32), .MSB_FIRST(0)) u_a (.clk_i(clk), .rst_i(rst), .bus(a_if), .busy_o(a_busy));
    priority_scanner #(.WIDTH(32), .MSB_FIRST(1)) u_m (.clk_i(clk), .rst_i(rst), .bus(m_if), .busy_o(m_busy));
    priority_scanner #(.WIDTH(2), .MSB_FIRST(0)) u_n (.clk_i(clk), .rst_i(rst), .bus(n_if), .busy_o(n_busy));
    priority_scanner #(.WIDTH(256), .MSB_FIRST(0)) u_w (.clk_i(clk), .rst_i(rst), .bus(w_if), .busy_o(w_busy));
    assign a_cnt = '0;
    assign m_cnt = '0;
    assign n_cnt = '0;
    assign w_cnt = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        a_if.load_valid_i = 0; a_if.load_data_i = '0; a_if.idx_ready_i = 1;
        m_if.load_valid_i = 0; m_if.load_data_i = '0; m_if.idx_ready_i = 1;
        n_if.load_valid_i = 0; n_if.load_data_i = '0; n_if.idx_ready_i = 1;
        w_if.load_valid_i = 0; w_if.load_data_i = '0; w_if.idx_ready_i = 1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(a_if.load_ready_o), 0);
        chk("rst_valid", 32'(a_if.idx_valid_o), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_idx", 32'(a_if.idx_o), 0);
        chk("rst_last", 32'(a_if.last_o), 0);
        rst = 0;
        #1 chk("ready_after_rst", 32'(a_if.load_ready_o), 1);
        // basic drain, lowest bit first
        a_if.load_valid_i = 1; a_if.load_data_i = 32'h8000_0011;
        @(negedge clk);
        a_if.load_valid_i = 0;
        chk("basic_idx0", 32'(a_if.idx_o), 0);
        chk("basic_last0", 32'(a_if.last_o), 0);
        chk("basic_busy", 32'(a_busy), 1);
`ifdef PRIO_SCAN_COUNT_EN
        chk("basic_cnt", 32'(a_cnt), 3);
`endif
        @(negedge clk);
        chk("basic_idx1", 32'(a_if.idx_o), 4);
        chk("basic_last1", 32'(a_if.last_o), 0);
        @(negedge clk);
        chk("basic_idx2", 32'(a_if.idx_o), 31);
        chk("basic_last2", 32'(a_if.last_o), 1);
        chk("basic_ready_drain", 32'(a_if.load_ready_o), 1);
        @(negedge clk);
        chk("basic_idle_busy", 32'(a_busy), 0);
        chk("basic_idle_valid", 32'(a_if.idx_valid_o), 0);
        // backpressure
        a_if.idx_ready_i = 0; a_if.load_valid_i = 1; a_if.load_data_i = 32'h0000_0006;
        @(negedge clk);
        a_if.load_valid_i = 0; a_if.load_data_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            chk("bp_idx", 32'(a_if.idx_o), 1);
            chk("bp_last", 32'(a_if.last_o), 0);
            chk("bp_ready", 32'(a_if.load_ready_o), 0);
            @(negedge clk);
        end
        chk("bp_hold_idx", 32'(a_if.idx_o), 1);
        a_if.idx_ready_i = 1;
        @(negedge clk);
        chk("bp_idx2", 32'(a_if.idx_o), 2);
        chk("bp_last2", 32'(a_if.last_o), 1);
        @(negedge clk);
        chk("bp_idle", 32'(a_if.idx_valid_o), 0);
        // all-zero vector is swallowed
        a_if.load_valid_i = 1; a_if.load_data_i = '0;
        #1 chk("zero_ready", 32'(a_if.load_ready_o), 1);
        @(negedge clk);
        a_if.load_valid_i = 0;
        chk("zero_valid", 32'(a_if.idx_valid_o), 0);
        chk("zero_busy", 32'(a_busy), 0);
        @(negedge clk);
        chk("zero_valid2", 32'(a_if.idx_valid_o), 0);
        // back-to-back load on the draining cycle
        a_if.load_valid_i = 1; a_if.load_data_i = 32'h0000_0001;
        @(negedge clk);
        chk("b2b_idx0", 32'(a_if.idx_o), 0);
        chk("b2b_last0", 32'(a_if.last_o), 1);
        a_if.load_data_i = 32'h0000_0002;
        #1 chk("b2b_ready", 32'(a_if.load_ready_o), 1);
        @(negedge clk);
        a_if.load_valid_i = 0;
        chk("b2b_valid1", 32'(a_if.idx_valid_o), 1);
        chk("b2b_idx1", 32'(a_if.idx_o), 1);
        chk("b2b_last1", 32'(a_if.last_o), 1);
        @(negedge clk);
        chk("b2b_idle", 32'(a_if.idx_valid_o), 0);
        // reset mid-scan
        a_if.load_valid_i = 1; a_if.load_data_i = 32'hFFFF_FFFF;
        @(negedge clk);
        a_if.load_valid_i = 0;
        chk("mid_idx0", 32'(a_if.idx_o), 0);
        @(negedge clk);
        chk("mid_idx1", 32'(a_if.idx_o), 1);
`ifdef PRIO_SCAN_COUNT_EN
        chk("mid_cnt_pre", 32'(a_cnt), 31);
`endif
        rst = 1;
        @(negedge clk);
        chk("mid_valid", 32'(a_if.idx_valid_o), 0);
        chk("mid_busy", 32'(a_busy), 0);
        chk("mid_idx", 32'(a_if.idx_o), 0);
        chk("mid_ready_rst", 32'(a_if.load_ready_o), 0);
`ifdef PRIO_SCAN_COUNT_EN
        chk("mid_cnt_post", 32'(a_cnt), 0);
`endif
        rst = 0;
        // highest bit first
        m_if.load_valid_i = 1; m_if.load_data_i = 32'h8000_0011;
        @(negedge clk);
        m_if.load_valid_i = 0;
        chk("msb_idx0", 32'(m_if.idx_o), 31);
        chk("msb_last0", 32'(m_if.last_o), 0);
        @(negedge clk);
        chk("msb_idx1", 32'(m_if.idx_o), 4);
        chk("msb_last1", 32'(m_if.last_o), 0);
        @(negedge clk);
        chk("msb_idx2", 32'(m_if.idx_o), 0);
        chk("msb_last2", 32'(m_if.last_o), 1);
        @(negedge clk);
        chk("msb_idle", 32'(m_busy), 0);
        // width 2
        n_if.load_valid_i = 1; n_if.load_data_i = 2'b11;
        @(negedge clk);
        n_if.load_valid_i = 0;
        chk("w2_idx0", 32'(n_if.idx_o), 0);
        chk("w2_last0", 32'(n_if.last_o), 0);
`ifdef PRIO_SCAN_COUNT_EN
        chk("w2_cnt", 32'(n_cnt), 2);
`endif
        @(negedge clk);
        chk("w2_idx1", 32'(n_if.idx_o), 1);
        chk("w2_last1", 32'(n_if.last_o), 1);
        @(negedge clk);
        chk("w2_idle", 32'(n_busy), 0);
        // width 256
        w_if.load_valid_i = 1; w_if.load_data_i = '1;
        @(negedge clk);
        w_if.load_valid_i = 0;
`ifdef PRIO_SCAN_COUNT_EN
        chk("w256_cnt", 32'(w_cnt), 256);
`endif
        for (int i = 0; i < 256; i++) begin
            chk("w256_idx", 32'(w_if.idx_o), 32'(i));
            chk("w256_last", 32'(w_if.last_o), 32'(i == 255));
            @(negedge clk);
        end
        chk("w256_idle", 32'(w_busy), 0);
        chk("unused_cnt", 32'(a_cnt) | 32'(m_cnt), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
